// File: rtl/mem_align_pkg.sv
// Shared encodings and lane helpers for the load/store alignment stage.
// Little-endian: lane i carries byte address offset i within the word.
package mem_align_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int WAIT_LIMIT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lane[0];
            SZ_WORD: mis = (lane != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicating the datum across all lanes lets byte enables alone pick the target lane.
    function automatic logic [31:0] pack_store(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] packed_data;
        case (size)
            SZ_BYTE: packed_data = {4{wdata[7:0]}};
            SZ_HALF: packed_data = {2{wdata[15:0]}};
            SZ_WORD: packed_data = wdata;
            default: packed_data = 32'h0000_0000;
        endcase
        return packed_data;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select with sign/zero extension to 32 bits.
// Word loads pass through unchanged; illegal size yields zero.
module load_extend
    import mem_align_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [31:0] w_byte_sh;
    logic [31:0] w_half_sh;

    // Shift the addressed lane down to bit 0, then extend per size.
    always_comb begin
        w_byte_sh = i_rdata >> {i_addr, 3'b000};
        w_half_sh = i_rdata >> {i_addr[1], 4'b0000};
        o_data    = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_signed & w_byte_sh[7]}}, w_byte_sh[7:0]};
            SZ_HALF: o_data = {{16{i_signed & w_half_sh[15]}}, w_half_sh[15:0]};
            SZ_WORD: o_data = i_rdata;
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment stage: captures a datapath request, drives a
// variable-latency memory with en/ack, and returns one registered response.
module mem_align_unit
    import mem_align_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misalign,
    output logic        resp_err
);

    state_t      r_state;
    logic        r_write;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [31:0] r_cnt;

    logic        w_accept;
    logic        w_misal;
    logic        w_timeout;
    logic [31:0] w_ext;

    assign w_accept  = req_valid && req_ready;
    assign w_misal   = is_misaligned(req_size, req_addr[1:0]);
    // This is the last permitted waiting cycle; WAIT_LIMIT of zero disables the timeout.
    assign w_timeout = (WAIT_LIMIT != 0) && (r_cnt == 32'(WAIT_LIMIT - 1));

    load_extend u_load_extend (
        .i_addr   (r_lane),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_rdata  (mem_rdata),
        .o_data   (w_ext)
    );

    // Request FSM with capture registers, timeout counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_write       <= 1'b0;
            r_signed      <= 1'b0;
            r_size        <= 2'b00;
            r_lane        <= 2'b00;
            r_cnt         <= 32'd0;
            req_ready     <= 1'b1;
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_be        <= 4'b0000;
            mem_addr      <= 32'h0000_0000;
            mem_wdata     <= 32'h0000_0000;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'h0000_0000;
            resp_misalign <= 1'b0;
            resp_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write   <= req_write;
                        r_signed  <= req_signed;
                        r_size    <= req_size;
                        r_lane    <= req_addr[1:0];
                        r_cnt     <= 32'd0;
                        req_ready <= 1'b0;
                        if (w_misal) begin
                            r_state       <= ST_RESP;
                            resp_valid    <= 1'b1;
                            resp_misalign <= 1'b1;
                            resp_err      <= 1'b0;
                            resp_rdata    <= 32'h0000_0000;
                        end else begin
                            r_state   <= ST_ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= req_write;
                            mem_be    <= lane_enables(req_size, req_addr[1:0]);
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= pack_store(req_size, req_wdata);
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // Ack is checked first so a same-cycle ack beats the timeout.
                    if (mem_ack || w_timeout) begin
                        r_state       <= ST_RESP;
                        r_cnt         <= 32'd0;
                        mem_en        <= 1'b0;
                        mem_we        <= 1'b0;
                        mem_be        <= 4'b0000;
                        mem_addr      <= 32'h0000_0000;
                        mem_wdata     <= 32'h0000_0000;
                        resp_valid    <= 1'b1;
                        resp_misalign <= 1'b0;
                        resp_err      <= !mem_ack;
                        resp_rdata    <= (mem_ack && !r_write) ? w_ext : 32'h0000_0000;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_RESP: begin
                    r_state       <= ST_IDLE;
                    req_ready     <= 1'b1;
                    resp_valid    <= 1'b0;
                    resp_rdata    <= 32'h0000_0000;
                    resp_misalign <= 1'b0;
                    resp_err      <= 1'b0;
                end
                default: begin
                    r_state       <= ST_IDLE;
                    req_ready     <= 1'b1;
                    mem_en        <= 1'b0;
                    mem_we        <= 1'b0;
                    resp_valid    <= 1'b0;
                    resp_misalign <= 1'b0;
                    resp_err      <= 1'b0;
                end
            endcase
        end
    end

endmodule
